// File: rtl/core_pkg.sv
// Shared core definitions: cache request tag fields and the store-buffer drain states.
package core_pkg;

   localparam logic WRITE  = 1'b1;
   localparam logic MEMORY = 1'b1;
   localparam logic DATA   = 1'b1;

   typedef struct packed {
      logic       write;
      logic       memory;
      logic       data;
      logic [6:0] rsvd;
   } req_tag_t;

   localparam req_tag_t STORE_TAG = '{write: WRITE, memory: MEMORY, data: DATA, rsvd: 7'b0};

   typedef enum logic [1:0] {
      SB_IDLE = 2'd0,
      SB_REQ  = 2'd1,
      SB_WAIT = 2'd2
   } sb_state_t;

endpackage

// File: rtl/wb_store_buffer_if.sv
// WriteBack push channel and D-cache request channel of the store buffer.
interface wb_store_buffer_if
   import core_pkg::*;
#(
   parameter int unsigned ADDR_W = 64,
   parameter int unsigned DATA_W = 64
) ();

   logic              push_valid;
   logic [ADDR_W-1:0] push_addr;
   logic [DATA_W-1:0] push_data;
   logic              push_ready;

   logic              reqcyc;
   logic [ADDR_W-1:0] req;
   logic [DATA_W-1:0] reqdata;
   req_tag_t          reqtag;
   logic              reqack;
   logic              writeack;

   // master is the store buffer; slave is WriteBack plus the cache
   modport master (
      input  push_valid, push_addr, push_data, reqack, writeack,
      output push_ready, reqcyc, req, reqdata, reqtag
   );

   modport slave (
      output push_valid, push_addr, push_data, reqack, writeack,
      input  push_ready, reqcyc, req, reqdata, reqtag
   );

endinterface

// File: rtl/wb_sb_fifo.sv
// Circular store storage: allocate at tail, rewrite the youngest entry, pop at head,
// with every slot visible in parallel for forwarding.
module wb_sb_fifo #(
   parameter  int unsigned DEPTH  = 4,
   parameter  int unsigned ADDR_W = 64,
   parameter  int unsigned DATA_W = 64,
   localparam int unsigned PTR_W  = $clog2(DEPTH),
   localparam int unsigned CNT_W  = PTR_W + 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           alloc_en,
   input  logic                           coal_en,
   input  logic                           pop_en,
   input  logic [ADDR_W-1:0]              wr_addr,
   input  logic [DATA_W-1:0]              wr_data,
   output logic [PTR_W-1:0]               head,
   output logic [PTR_W-1:0]               tail,
   output logic [CNT_W-1:0]               count,
   output logic [DEPTH-1:0][ADDR_W-1:0]   ent_addr,
   output logic [DEPTH-1:0][DATA_W-1:0]   ent_data
);

   logic [PTR_W-1:0]             head_q, head_d;
   logic [PTR_W-1:0]             tail_q, tail_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
   logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
   logic [PTR_W-1:0]             last_idx;

   assign last_idx = tail_q - PTR_W'(1);

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      addr_d  = addr_q;
      data_d  = data_q;
      if (alloc_en) begin
         addr_d[tail_q] = wr_addr;
         data_d[tail_q] = wr_data;
         tail_d         = tail_q + PTR_W'(1);
      end else if (coal_en) begin
         data_d[last_idx] = wr_data;
      end
      if (pop_en) begin
         head_d = head_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(alloc_en) - CNT_W'(pop_en);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
      end
   end

   assign head     = head_q;
   assign tail     = tail_q;
   assign count    = count_q;
   assign ent_addr = addr_q;
   assign ent_data = data_q;

endmodule

// File: rtl/wb_store_buffer.sv
// Posted-write store buffer between WriteBack and the D-cache: in-order drain FSM,
// youngest-match load forwarding and optional coalescing into the youngest entry.
module wb_store_buffer
   import core_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned ADDR_W   = 64,
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned COALESCE = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   wb_store_buffer_if.master        bus,
   input  logic [ADDR_W-1:0]        fwd_addr,
   output logic                     fwd_hit,
   output logic [DATA_W-1:0]        fwd_data,
   input  logic                     drain_all,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     mem_inprogress
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [PTR_W-1:0]             head, tail, last_idx, fwd_idx;
   logic [CNT_W-1:0]             cnt;
   logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
   logic [DEPTH-1:0][DATA_W-1:0] ent_data;
   logic                         head_is_last, coalesce_ok, push_ok;
   logic                         push_fire, alloc_en, coal_en, pop_en;

   sb_state_t         state_q, state_d;
   logic              reqcyc_q, reqcyc_d;
   logic [ADDR_W-1:0] req_q, req_d;
   logic [DATA_W-1:0] reqdata_q, reqdata_d;
   req_tag_t          reqtag_q, reqtag_d;

   wb_sb_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .alloc_en (alloc_en),
      .coal_en  (coal_en),
      .pop_en   (pop_en),
      .wr_addr  (bus.push_addr),
      .wr_data  (bus.push_data),
      .head     (head),
      .tail     (tail),
      .count    (cnt),
      .ent_addr (ent_addr),
      .ent_data (ent_data)
   );

   // The in-flight head must not change under the cache, so it only coalesces while idle
   assign last_idx     = tail - PTR_W'(1);
   assign head_is_last = (last_idx == head);
   assign coalesce_ok  = (COALESCE != 0) && (cnt != '0) &&
                         (ent_addr[last_idx] == bus.push_addr) &&
                         !(head_is_last && (state_q != SB_IDLE));
   assign push_ok      = ((cnt < CNT_W'(DEPTH)) || coalesce_ok) && !drain_all;
   assign push_fire    = bus.push_valid && push_ok;
   assign alloc_en     = push_fire && !coalesce_ok;
   assign coal_en      = push_fire && coalesce_ok;

   always_comb begin
      state_d   = state_q;
      reqcyc_d  = reqcyc_q;
      req_d     = req_q;
      reqdata_d = reqdata_q;
      reqtag_d  = reqtag_q;
      pop_en    = 1'b0;
      case (state_q)
         SB_IDLE: begin
            if (cnt != '0) begin
               state_d   = SB_REQ;
               reqcyc_d  = 1'b1;
               req_d     = ent_addr[head];
               // a coalesce landing on the head this edge must go out with the request
               reqdata_d = (coal_en && head_is_last) ? bus.push_data : ent_data[head];
               reqtag_d  = STORE_TAG;
            end
         end
         SB_REQ: begin
            if (bus.reqack) begin
               reqcyc_d = 1'b0;
               if (bus.writeack) begin
                  pop_en  = 1'b1;
                  state_d = SB_IDLE;
               end else begin
                  state_d = SB_WAIT;
               end
            end
         end
         SB_WAIT: begin
            if (bus.writeack) begin
               pop_en  = 1'b1;
               state_d = SB_IDLE;
            end
         end
         default: state_d = SB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= SB_IDLE;
         reqcyc_q  <= 1'b0;
         req_q     <= '0;
         reqdata_q <= '0;
         reqtag_q  <= req_tag_t'('0);
      end else begin
         state_q   <= state_d;
         reqcyc_q  <= reqcyc_d;
         req_q     <= req_d;
         reqdata_q <= reqdata_d;
         reqtag_q  <= reqtag_d;
      end
   end

   // Walk oldest to youngest so the last match is the youngest
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = head + PTR_W'(i);
         if ((CNT_W'(i) < cnt) && (ent_addr[fwd_idx] == fwd_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = ent_data[fwd_idx];
         end
      end
   end

   assign bus.push_ready = push_ok;
   assign bus.reqcyc     = reqcyc_q;
   assign bus.req        = req_q;
   assign bus.reqdata    = reqdata_q;
   assign bus.reqtag     = reqtag_q;
   assign count          = cnt;
   assign empty          = (cnt == '0) && (state_q == SB_IDLE);
   assign mem_inprogress = !empty;

endmodule

// File: tb/tb_wb_store_buffer.sv
// Store buffer bench: a coalescing and a non-coalescing instance share stimulus and
// are compared every cycle against a list-based reference model.
module tb_wb_store_buffer;
   import core_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, push_valid, drain_all, reqack, writeack;
   logic [63:0] push_addr, push_data, fwd_addr;

   wb_store_buffer_if #(.ADDR_W(64), .DATA_W(64)) bi0 ();
   wb_store_buffer_if #(.ADDR_W(64), .DATA_W(64)) bi1 ();

   assign bi0.push_valid = push_valid;
   assign bi0.push_addr  = push_addr;
   assign bi0.push_data  = push_data;
   assign bi0.reqack     = reqack;
   assign bi0.writeack   = writeack;
   assign bi1.push_valid = push_valid;
   assign bi1.push_addr  = push_addr;
   assign bi1.push_data  = push_data;
   assign bi1.reqack     = reqack;
   assign bi1.writeack   = writeack;

   logic        fwd_hit0, fwd_hit1, empty0, empty1, mip0, mip1;
   logic [63:0] fwd_data0, fwd_data1;
   logic [2:0]  count0, count1;

   wb_store_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64), .COALESCE(1)) dut0 (
      .clk(clk), .reset(reset), .bus(bi0), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit0),
      .fwd_data(fwd_data0), .drain_all(drain_all), .empty(empty0), .count(count0),
      .mem_inprogress(mip0)
   );

   wb_store_buffer #(.DEPTH(4), .ADDR_W(64), .DATA_W(64), .COALESCE(0)) dut1 (
      .clk(clk), .reset(reset), .bus(bi1), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit1),
      .fwd_data(fwd_data1), .drain_all(drain_all), .empty(empty1), .count(count1),
      .mem_inprogress(mip1)
   );

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: entry lists (index 0 = oldest) plus cache transaction phase
   // (0 none, 1 awaiting reqack, 2 awaiting writeack) and expected bus outputs.
   logic [63:0] m_a [2][8];
   logic [63:0] m_d [2][8];
   int          m_len [2];
   int          m_phase [2];
   logic        m_rc [2];
   logic [63:0] m_req [2];
   logic [63:0] m_rd [2];
   logic [63:0] m_tag [2];

   function automatic bit m_coal(input int k);
      if (k != 0 || m_len[k] == 0) return 1'b0;
      if (m_a[k][m_len[k]-1] != push_addr) return 1'b0;
      if (m_len[k] == 1 && m_phase[k] != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit m_ready(input int k);
      return (m_len[k] < 4 || m_coal(k)) && !drain_all;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_len[k] = 0; m_phase[k] = 0; m_rc[k] = 1'b0;
         m_req[k] = '0; m_rd[k] = '0; m_tag[k] = '0;
      end
   endtask

   task automatic model_step(input int k);
      bit coal, fire, pop;
      if (!reset) begin
         m_len[k] = 0; m_phase[k] = 0; m_rc[k] = 1'b0;
         m_req[k] = '0; m_rd[k] = '0; m_tag[k] = '0;
         return;
      end
      coal = m_coal(k);
      fire = push_valid && m_ready(k);
      pop  = 1'b0;
      if (m_phase[k] == 0) begin
         if (m_len[k] > 0) begin
            m_phase[k] = 1;
            m_rc[k]    = 1'b1;
            m_req[k]   = m_a[k][0];
            m_rd[k]    = (fire && coal && m_len[k] == 1) ? push_data : m_d[k][0];
            m_tag[k]   = 64'h380;
         end
      end else if (m_phase[k] == 1) begin
         if (reqack) begin
            m_rc[k] = 1'b0;
            if (writeack) begin pop = 1'b1; m_phase[k] = 0; end
            else m_phase[k] = 2;
         end
      end else if (writeack) begin
         pop = 1'b1; m_phase[k] = 0;
      end
      if (fire) begin
         if (coal) m_d[k][m_len[k]-1] = push_data;
         else begin
            m_a[k][m_len[k]] = push_addr;
            m_d[k][m_len[k]] = push_data;
            m_len[k]++;
         end
      end
      if (pop) begin
         for (int j = 0; j + 1 < m_len[k]; j++) begin
            m_a[k][j] = m_a[k][j+1];
            m_d[k][j] = m_d[k][j+1];
         end
         m_len[k]--;
      end
   endtask

   task automatic check_inst(input int k, input string p, input logic rc, input logic [63:0] rq,
                             input logic [63:0] rd, input logic [63:0] rt, input logic pr,
                             input logic [2:0] cnt, input logic emp, input logic mip,
                             input logic fh, input logic [63:0] fd);
      logic        eh;
      logic [63:0] ed;
      logic        ee;
      eh = 1'b0; ed = '0;
      for (int j = 0; j < m_len[k]; j++) begin
         if (m_a[k][j] == fwd_addr) begin eh = 1'b1; ed = m_d[k][j]; end
      end
      ee = (m_len[k] == 0) && (m_phase[k] == 0);
      check_val({p, "reqcyc"},  64'(rc),  64'(m_rc[k]));
      check_val({p, "req"},     rq,       m_req[k]);
      check_val({p, "reqdata"}, rd,       m_rd[k]);
      check_val({p, "reqtag"},  rt,       m_tag[k]);
      check_val({p, "ready"},   64'(pr),  64'(m_ready(k)));
      check_val({p, "count"},   64'(cnt), 64'(m_len[k]));
      check_val({p, "empty"},   64'(emp), 64'(ee));
      check_val({p, "inprog"},  64'(mip), 64'(!ee));
      check_val({p, "fwd_hit"}, 64'(fh),  64'(eh));
      check_val({p, "fwd_data"}, fd,      ed);
   endtask

   // Requests seen at each instance (data on reqcyc rise, and the cycle it rose)
   logic        prev_rc0 = 1'b0, prev_rc1 = 1'b0;
   logic [63:0] rec0 [16];
   logic [63:0] rec1 [16];
   int          rt1 [16];
   int          nrec0 = 0, nrec1 = 0;

   task automatic tick();
      #1;
      check_inst(0, "c1_", bi0.reqcyc, bi0.req, bi0.reqdata, 64'(bi0.reqtag), bi0.push_ready,
                 count0, empty0, mip0, fwd_hit0, fwd_data0);
      check_inst(1, "c0_", bi1.reqcyc, bi1.req, bi1.reqdata, 64'(bi1.reqtag), bi1.push_ready,
                 count1, empty1, mip1, fwd_hit1, fwd_data1);
      if (bi0.reqcyc && !prev_rc0 && nrec0 < 16) begin rec0[nrec0] = bi0.reqdata; nrec0++; end
      if (bi1.reqcyc && !prev_rc1 && nrec1 < 16) begin
         rec1[nrec1] = bi1.reqdata; rt1[nrec1] = cyc; nrec1++;
      end
      prev_rc0 = bi0.reqcyc;
      prev_rc1 = bi1.reqcyc;
      @(posedge clk);
      model_step(0);
      model_step(1);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0; push_valid = 1'b0; reqack = 1'b0; writeack = 1'b0; drain_all = 1'b0;
      tick(); tick();
      reset = 1'b1;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] d);
      push_valid = 1'b1; push_addr = a; push_data = d;
      tick();
      push_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b0; push_valid = 1'b0; push_addr = '0; push_data = '0;
      fwd_addr = 64'hdead; drain_all = 1'b0; reqack = 1'b0; writeack = 1'b0;
      repeat (2) @(posedge clk);
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_val("rst_empty", 64'(empty0), 64'd1);
      check_val("rst_count", 64'(count0), 64'd0);
      check_val("rst_reqcyc", 64'(bi0.reqcyc), 64'd0);
      check_val("rst_ready", 64'(bi0.push_ready), 64'd1);
      check_val("rst_fwd_hit", 64'(fwd_hit0), 64'd0);

      // single store: reqack one cycle after reqcyc, writeack two cycles after that
      nrec0 = 0;
      push(64'h1000, 64'h11);
      tick();
      tick();
      reqack = 1'b1; tick(); reqack = 1'b0;
      tick();
      writeack = 1'b1; tick(); writeack = 1'b0;
      tick();
      check_val("single_nreq", 64'(nrec0), 64'd1);
      check_val("single_data", rec0[0], 64'h11);
      check_val("single_empty", 64'(empty0), 64'd1);

      // full buffer with the cache stalled, then coalesce into the youngest entry
      do_reset();
      nrec0 = 0;
      for (int i = 0; i < 4; i++) push(64'h3000 + 64'(8 * i), 64'h31 + 64'(i));
      push_valid = 1'b1; push_addr = 64'h4000; push_data = 64'h55;
      #1;
      check_val("full_count", 64'(count0), 64'd4);
      check_val("full_ready", 64'(bi0.push_ready), 64'd0);
      tick(); tick();
      push_addr = 64'h3018; push_data = 64'h99;
      #1;
      check_val("coal_ready", 64'(bi0.push_ready), 64'd1);
      tick();
      push_valid = 1'b0;
      reqack = 1'b1; writeack = 1'b1;
      repeat (12) tick();
      reqack = 1'b0; writeack = 1'b0;
      check_val("coal_nreq", 64'(nrec0), 64'd4);
      check_val("coal_last", rec0[3], 64'h99);
      check_val("coal_empty", 64'(empty0), 64'd1);

      // same address twice: separate entries without coalescing, head bypass with it
      do_reset();
      nrec0 = 0; nrec1 = 0;
      push(64'h2000, 64'h1);
      push(64'h2000, 64'h2);
      fwd_addr = 64'h2000;
      #1;
      check_val("nc_fwd_hit", 64'(fwd_hit1), 64'd1);
      check_val("nc_fwd_data", fwd_data1, 64'h2);
      check_val("nc_count", 64'(count1), 64'd2);
      check_val("co_count", 64'(count0), 64'd1);
      reqack = 1'b1; writeack = 1'b1;
      repeat (8) tick();
      reqack = 1'b0; writeack = 1'b0;
      check_val("nc_nreq", 64'(nrec1), 64'd2);
      check_val("nc_order0", rec1[0], 64'h1);
      check_val("nc_order1", rec1[1], 64'h2);
      check_val("nc_b2b_gap", 64'(rt1[1] - rt1[0]), 64'd2);
      check_val("co_head_bypass", rec0[0], 64'h2);

      // reset while waiting for writeack with three entries
      do_reset();
      for (int i = 0; i < 3; i++) push(64'h5000 + 64'(8 * i), 64'h50 + 64'(i));
      tick();
      reqack = 1'b1; tick(); reqack = 1'b0;
      tick();
      check_val("wait_count", 64'(count0), 64'd3);
      reset = 1'b0; tick(); reset = 1'b1;
      writeack = 1'b1;
      #1;
      check_val("rstw_count", 64'(count0), 64'd0);
      check_val("rstw_reqcyc", 64'(bi0.reqcyc), 64'd0);
      tick(); tick();
      writeack = 1'b0;
      check_val("rstw_late_ack", 64'(empty0), 64'd1);

      // randomized traffic over a small address set
      for (int n = 0; n < 2500; n++) begin
         reset      = ($urandom_range(0, 399) != 0);
         push_valid = $urandom_range(0, 1) != 0;
         push_addr  = 64'h1000 + 64'(8 * $urandom_range(0, 3));
         push_data  = {$urandom, $urandom};
         fwd_addr   = 64'h1000 + 64'(8 * $urandom_range(0, 4));
         drain_all  = ($urandom_range(0, 9) == 0);
         reqack     = $urandom_range(0, 2) != 0;
         writeack   = $urandom_range(0, 2) != 0;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
